// File: rtl/sw_io_pkg.sv
// Shared types and helpers for the front-panel I/O sequencer.
package sw_io_pkg;

    typedef enum logic [1:0] {
        CAPTURE  = 2'd0,
        WAIT_RES = 2'd1,
        SHOW     = 2'd2
    } io_state_t;

    // Index/counter width for a bound n; never narrower than one bit.
    function automatic int idx_w(input int n);
        int w;
        w = $clog2(n);
        if (w < 1) begin
            w = 1;
        end else begin
            w = w;
        end
        return w;
    endfunction

endpackage

// File: rtl/sw_io_sequencer_sync_debounce.sv
// Synchroniser plus debouncer for the bouncy ready button; emits a
// one-cycle press pulse on each debounced rising edge.
module sync_debounce
    import sw_io_pkg::*;
#(
    parameter int SYNC_STAGES  = 2,
    parameter int DEBOUNCE_CYC = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic press
);

    localparam int CW = idx_w(DEBOUNCE_CYC);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   ready_s;
    logic [CW-1:0]          cnt_r;
    logic                   db_r;
    logic                   db_d_r;
    logic                   press_r;

    assign ready_s = sync_r[SYNC_STAGES-1];
    assign press   = press_r;

    // Metastability chain for the asynchronous button input.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync_r <= '0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], din};
        end
    end

    // Debounced level only follows a difference that persists long enough.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_r <= '0;
            db_r  <= 1'b0;
        end else if (ready_s != db_r) begin
            if (cnt_r == CNT_LAST) begin
                db_r  <= ready_s;
                cnt_r <= '0;
            end else begin
                cnt_r <= cnt_r + CW'(1);
            end
        end else begin
            cnt_r <= '0;
        end
    end

    // Rising-edge detect on the debounced level.
    always_ff @(posedge clk) begin
        if (!reset) begin
            db_d_r  <= 1'b0;
            press_r <= 1'b0;
        end else begin
            db_d_r  <= db_r;
            press_r <= db_r & ~db_d_r;
        end
    end

endmodule

// File: rtl/sw_io_sequencer.sv
// Front-panel sequencer: captures N_IN operands from the switches, hands
// them to the core, waits (with timeout) for results and pages them on LED.
module sw_io_sequencer
    import sw_io_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int N_IN         = 2,
    parameter int N_OUT        = 2,
    parameter int SYNC_STAGES  = 2,
    parameter int DEBOUNCE_CYC = 4,
    parameter int TIMEOUT_CYC  = 1024,
    parameter int ECHO_SW      = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [DATA_W-1:0]       sw,
    input  logic                    ready,
    output logic [DATA_W-1:0]       LED,
    output logic [N_IN*DATA_W-1:0]  op_data,
    output logic                    op_valid,
    input  logic [N_OUT*DATA_W-1:0] res_data,
    input  logic                    res_valid,
    output logic                    busy,
    output logic                    err
);

    localparam int KW = idx_w(N_IN);
    localparam int JW = idx_w(N_OUT);
    localparam int TW = idx_w(TIMEOUT_CYC);
    localparam logic [KW-1:0] K_LAST   = KW'(N_IN - 1);
    localparam logic [JW-1:0] J_LAST   = JW'(N_OUT - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

    logic [DATA_W-1:0]       sw_sync_r [SYNC_STAGES];
    logic [DATA_W-1:0]       sw_s;
    logic                    press_s;
    logic [DATA_W-1:0]       cur_res_s;
    io_state_t               state_r;
    logic [KW-1:0]           k_r;
    logic [JW-1:0]           j_r;
    logic [TW-1:0]           tmo_r;
    logic [N_OUT*DATA_W-1:0] res_r;

    assign sw_s = sw_sync_r[SYNC_STAGES-1];

    sync_debounce #(
        .SYNC_STAGES  (SYNC_STAGES),
        .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) u_ready_db (
        .clk   (clk),
        .reset (reset),
        .din   (ready),
        .press (press_s)
    );

    // Switch synchroniser, same depth as the button path.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sw_sync_r[i] <= '0;
            end
        end else begin
            sw_sync_r[0] <= sw;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sw_sync_r[i] <= sw_sync_r[i-1];
            end
        end
    end

    // Select the result word currently being displayed.
    always_comb begin
        cur_res_s = '0;
        for (int i = 0; i < N_OUT; i++) begin
            if (j_r == JW'(i)) begin
                cur_res_s = res_r[i*DATA_W +: DATA_W];
            end else begin
                cur_res_s = cur_res_s;
            end
        end
    end

    // Transaction state machine with registered outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r  <= CAPTURE;
            k_r      <= '0;
            j_r      <= '0;
            tmo_r    <= '0;
            res_r    <= '0;
            LED      <= '0;
            op_data  <= '0;
            op_valid <= 1'b0;
            busy     <= 1'b0;
            err      <= 1'b0;
        end else begin
            op_valid <= 1'b0;
            case (state_r)
                CAPTURE: begin
                    busy <= 1'b0;
                    if (ECHO_SW != 0) begin
                        LED <= sw_s;
                    end else begin
                        LED <= DATA_W'(k_r);
                    end
                    if (press_s) begin
                        err <= 1'b0;
                        for (int i = 0; i < N_IN; i++) begin
                            if (k_r == KW'(i)) begin
                                op_data[i*DATA_W +: DATA_W] <= sw_s;
                            end
                        end
                        if (k_r == K_LAST) begin
                            k_r      <= '0;
                            op_valid <= 1'b1;
                            busy     <= 1'b1;
                            tmo_r    <= '0;
                            state_r  <= WAIT_RES;
                        end else begin
                            k_r <= k_r + KW'(1);
                        end
                    end
                end
                WAIT_RES: begin
                    // A result arriving on the timeout cycle still counts.
                    if (res_valid) begin
                        res_r   <= res_data;
                        j_r     <= '0;
                        busy    <= 1'b0;
                        state_r <= SHOW;
                    end else if (tmo_r == TMO_LAST) begin
                        err     <= 1'b1;
                        busy    <= 1'b0;
                        state_r <= CAPTURE;
                    end else begin
                        tmo_r <= tmo_r + TW'(1);
                    end
                end
                SHOW: begin
                    LED <= cur_res_s;
                    if (press_s) begin
                        if (j_r == J_LAST) begin
                            state_r <= CAPTURE;
                        end else begin
                            j_r <= j_r + JW'(1);
                        end
                    end
                end
                default: begin
                    state_r <= CAPTURE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sw_io_sequencer.sv
// Self-checking bench for sw_io_sequencer: directed vector table, glitch,
// bounce and reset sequences, then randomized transactions with timeouts.
module tb_sw_io_sequencer;

    localparam int DW = 8;
    localparam int T  = 64;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [DW-1:0] sw = '0;
    logic          ready = 1'b0;
    logic [DW-1:0] LED;
    logic [15:0]   op_data;
    logic          op_valid;
    logic [15:0]   res_data = '0;
    logic          res_valid = 1'b0;
    logic          busy;
    logic          err;

    int n_chk = 0;
    int n_fail = 0;
    int opv_hi = 0;
    int opv_pulses = 0;
    logic opv_prev = 1'b0;

    sw_io_sequencer #(
        .DATA_W(DW), .N_IN(2), .N_OUT(2), .SYNC_STAGES(2),
        .DEBOUNCE_CYC(4), .TIMEOUT_CYC(T), .ECHO_SW(1)
    ) dut (
        .clk(clk), .reset(reset), .sw(sw), .ready(ready), .LED(LED),
        .op_data(op_data), .op_valid(op_valid), .res_data(res_data),
        .res_valid(res_valid), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        opv_prev <= op_valid;
        if (op_valid) opv_hi <= opv_hi + 1;
        if (op_valid && !opv_prev) opv_pulses <= opv_pulses + 1;
    end

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] res;
        logic [15:0] exp_op;
        logic [7:0]  exp_l0;
        logic [7:0]  exp_l1;
    } vec_t;

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic press();
        ready = 1'b1;
        cyc(10);
        ready = 1'b0;
        cyc(10);
    endtask

    task automatic wait_busy();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (busy) begin
                ok = 1'b1;
                break;
            end
        end
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL wait_busy: busy never rose within 40 cycles");
        end
    endtask

    task automatic serve(input logic [15:0] r, input logic [7:0] last_sw, input string tag);
        res_data = r;
        res_valid = 1'b1;
        cyc(1);
        res_valid = 1'b0;
        cyc(4);
        chk({tag, "_led0"}, LED, r[7:0]);
        press();
        chk({tag, "_led1"}, LED, r[15:8]);
        press();
        chk({tag, "_busy_end"}, busy, 0);
        chk({tag, "_echo_end"}, LED, last_sw);
    endtask

    vec_t vecs[3];

    initial begin
        int p0, h0, d;
        logic [7:0] a, b;
        logic [15:0] r, prev_op;
        bit model_err;

        vecs[0] = '{8'h04, 8'h08, 16'h2010, 16'h0804, 8'h10, 8'h20};
        vecs[1] = '{8'h05, 8'h0A, 16'h140A, 16'h0A05, 8'h0A, 8'h14};
        vecs[2] = '{8'hFF, 8'h00, 16'h00FF, 16'h00FF, 8'hFF, 8'h00};

        // Reset held low, inputs active.
        sw = 8'h55;
        cyc(10);
        chk("rst_led", LED, 0);
        chk("rst_opv", op_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_op", op_data, 0);
        reset = 1'b1;
        cyc(4);
        chk("echo_after_rst", LED, 8'h55);

        // Directed vector table.
        for (int i = 0; i < 3; i++) begin
            p0 = opv_pulses; h0 = opv_hi;
            sw = vecs[i].a; cyc(4);
            chk("vec_echo_a", LED, vecs[i].a);
            press();
            chk("vec_busy_mid", busy, 0);
            sw = vecs[i].b;
            press();
            chk("vec_op", op_data, vecs[i].exp_op);
            chk("vec_busy", busy, 1);
            chk("vec_opv_pulses", opv_pulses - p0, 1);
            chk("vec_opv_width", opv_hi - h0, 1);
            res_data = vecs[i].res; res_valid = 1'b1; cyc(1); res_valid = 1'b0; cyc(4);
            chk("vec_led0", LED, vecs[i].exp_l0);
            press();
            chk("vec_led1", LED, vecs[i].exp_l1);
            press();
            chk("vec_busy_end", busy, 0);
            chk("vec_echo_end", LED, vecs[i].b);
        end

        // Short glitch: no capture, index unchanged.
        prev_op = op_data; p0 = opv_pulses;
        sw = 8'h33; cyc(4);
        ready = 1'b1; cyc(3); ready = 1'b0; cyc(15);
        chk("glitch_op", op_data, prev_op);
        chk("glitch_opv", opv_pulses - p0, 0);
        sw = 8'h11; press();
        sw = 8'h22; press();
        chk("glitch_after_op", op_data, 16'h2211);
        chk("glitch_after_opv", opv_pulses - p0, 1);
        serve(16'hBEEF, 8'h22, "glitch");

        // Bounce: three short toggles then stable high is one press.
        p0 = opv_pulses;
        sw = 8'h44; cyc(4);
        for (int i = 0; i < 3; i++) begin
            ready = 1'b1; cyc(1); ready = 1'b0; cyc(1);
        end
        ready = 1'b1; cyc(12); ready = 1'b0; cyc(10);
        chk("bounce_opv", opv_pulses - p0, 0);
        chk("bounce_busy", busy, 0);
        sw = 8'h66; press();
        chk("bounce_op", op_data, 16'h6644);
        chk("bounce_opv2", opv_pulses - p0, 1);
        serve(16'h1234, 8'h66, "bounce");

        // Reset in the middle of WAIT_RES.
        sw = 8'h01; press();
        sw = 8'h02; press();
        chk("midrst_busy_before", busy, 1);
        reset = 1'b0; cyc(3);
        chk("midrst_led", LED, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_err", err, 0);
        chk("midrst_op", op_data, 0);
        chk("midrst_opv", op_valid, 0);
        reset = 1'b1; cyc(4);
        chk("midrst_echo", LED, 8'h02);
        sw = 8'h03; press();
        sw = 8'h07; press();
        chk("midrst_op_after", op_data, 16'h0703);
        serve(16'h5A5A, 8'h07, "midrst");

        // Randomized transactions; the result must arrive within T cycles
        // of entering WAIT_RES, otherwise err is raised and the core's
        // late strobe is ignored.
        model_err = 1'b0;
        for (int i = 0; i < 10; i++) begin
            a = 8'($urandom); b = 8'($urandom); r = 16'($urandom);
            if (i == 0) d = T - 1;
            else if (i == 1) d = T;
            else d = int'($urandom_range(0, T + 8));
            p0 = opv_pulses;
            sw = a; cyc(4);
            chk("rnd_echo_a", LED, a);
            chk("rnd_err_before", err, model_err);
            press();
            model_err = 1'b0;
            chk("rnd_err_cleared", err, 0);
            sw = b; cyc(4);
            ready = 1'b1;
            wait_busy();
            ready = 1'b0;
            cyc(d);
            res_data = r; res_valid = 1'b1; cyc(1); res_valid = 1'b0;
            cyc(12);
            chk("rnd_op", op_data, {b, a});
            chk("rnd_opv", opv_pulses - p0, 1);
            if (d <= T - 1) begin
                chk("rnd_err_show", err, 0);
                chk("rnd_led0", LED, r[7:0]);
                press();
                chk("rnd_led1", LED, r[15:8]);
                press();
                chk("rnd_busy_end", busy, 0);
                chk("rnd_echo_end", LED, b);
            end else begin
                model_err = 1'b1;
                chk("rnd_err_tmo", err, 1);
                chk("rnd_busy_tmo", busy, 0);
                chk("rnd_echo_tmo", LED, b);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sw_io_sequencer.md
Name: sw_io_sequencer

Overview:
Parametrised front-panel I/O sequencer between the board switches/ready button and the picomips compute core. It synchronises and debounces `ready`, and captures N_IN operands from `sw` on successive presses. It then hands the operand vector to the core, waits for results with a timeout, and steps through N_OUT results on `LED`, one press per result. It generalises the fixed two-operand, two-result switch protocol to arbitrary width and counts, and adds debounce, echo mode and a timeout/error path.

Parameters:
- DATA_W, 8, width of `sw`, `LED` and each operand/result word.
- N_IN, 2, operands captured per transaction (>=1).
- N_OUT, 2, results displayed per transaction (>=1).
- SYNC_STAGES, 2, synchroniser flops on `ready` and `sw` (>=2).
- DEBOUNCE_CYC, 4, consecutive stable cycles needed to change the debounced level (>=1).
- TIMEOUT_CYC, 1024, maximum cycles in WAIT_RES before error.
- ECHO_SW, 1, 1: `LED` echoes synchronised `sw` in CAPTURE; 0: `LED` shows the capture index.

Ports:
- clk, in, 1, system clock, all logic on rising edge.
- reset, in, 1, synchronous active-low reset.
- sw, in, DATA_W, switch inputs, asynchronous.
- ready, in, 1, push button, asynchronous, bouncy.
- LED, out, DATA_W, display output.
- op_data, out, N_IN*DATA_W, captured operands; operand k is at [k*DATA_W +: DATA_W].
- op_valid, out, 1, one-cycle pulse when all operands are captured.
- res_data, in, N_OUT*DATA_W, core results, same packing as `op_data`.
- res_valid, in, 1, core result strobe.
- busy, out, 1, high in WAIT_RES.
- err, out, 1, sticky timeout flag, cleared by the next press.

Behaviour:
- Clock and reset: one clock, `clk`. Reset `reset` is synchronous and active-low. Reset has priority over all other logic, including mid-transaction.
- Reset values:
  - LED=0, op_data=0, op_valid=0, busy=0, err=0.
  - state=CAPTURE, all indices 0, sync chains 0, debounced level 0, debounce counter 0.
- Debounce:
  - `ready_s` is `ready` after SYNC_STAGES flops.
  - Counter increments each cycle `ready_s` differs from the debounced level `db`, and clears when they are equal.
  - When the counter reaches DEBOUNCE_CYC-1 and the levels still differ: `db` takes `ready_s` and the counter clears.
  - `press` is a registered one-cycle pulse on a 0->1 transition of `db`.
  - Latency from a clean `ready` rise to `press` high is SYNC_STAGES+DEBOUNCE_CYC+1 cycles.
  - A glitch shorter than DEBOUNCE_CYC cycles produces no press.
- Switch sampling: `sw_s` is `sw` through an identical SYNC_STAGES chain.
- State CAPTURE (index k):
  - On `press`: operand k takes `sw_s` and err clears.
  - If k==N_IN-1: k returns to 0, the next cycle asserts op_valid for exactly 1 cycle, and state goes to WAIT_RES.
  - Otherwise k increments.
  - LED = `sw_s` if ECHO_SW, else k zero-extended.
- State WAIT_RES:
  - busy=1; a timeout counter counts from 0.
  - On `res_valid`: all results are latched, j=0, state goes to SHOW.
  - If the timeout counter reaches TIMEOUT_CYC-1 without `res_valid`: err=1, state returns to CAPTURE.
  - Presses are ignored. If `res_valid` arrives in the same cycle as the timeout, `res_valid` wins.
- State SHOW (index j):
  - LED = result j.
  - On `press` with j<N_OUT-1: j increments.
  - On `press` with j==N_OUT-1: state returns to CAPTURE. This press is consumed and captures nothing.
- `res_valid` outside WAIT_RES is ignored.
- `op_data` holds its value until overwritten by the next capture.
- All index and counter widths use $clog2 of their bounds, minimum 1 bit. There is no arithmetic on data words.

Decomposition:
- Package `sw_io_pkg` holds the state enum `io_state_t` {CAPTURE, WAIT_RES, SHOW} and the helper function `idx_w(n)` = max(1, $clog2(n)).
- Sub-module `sync_debounce`, instantiated once for `ready`, provides the synchroniser, debounce counter, `db` and the `press` pulse.
- The `sw` synchroniser is inline.

Test Plan:
- Reset is low for 10 cycles -> LED=0, op_valid=0, busy=0, err=0. Asserting reset mid-WAIT_RES returns to CAPTURE with all outputs 0.
- sw=0x04, press; sw=0x08, press -> op_valid pulses 1 cycle; op_data=0x0804; busy=1.
- In WAIT_RES drive res_data=0x2010 with res_valid -> LED=0x10; press -> LED=0x20; press -> back in CAPTURE, LED echoes sw.
- Repeat with sw=0x05 then 0x0A and res_data=0x140A -> op_data=0x0A05, LED shows 0x0A then 0x14.
- `ready` glitch lasting DEBOUNCE_CYC-1 cycles -> no capture and k unchanged. Bouncing `ready` (3 toggles, then stable) -> exactly one capture.
- Withhold res_valid -> err=1 after TIMEOUT_CYC cycles and state is CAPTURE; next press clears err. With res_valid on the timeout cycle -> SHOW, err=0.
